// File: rtl/scalar_writeback_arbiter.sv
// Scalar writeback arbiter: two producer queues (ALU, load) merged onto a
// single register-file write port with round-robin arbitration and
// per-register pending-write flags for decode.

// One producer queue: DEPTH-entry FIFO plus its slice of the busy vector.
module scalar_writeback_arbiter_lane #(
  parameter int DATA_W = 36,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   valid,
  input  logic [ADDR_W-1:0]      addr,
  input  logic [DATA_W-1:0]      data,
  input  logic                   pop,
  output logic                   ready,
  output logic                   nonempty,
  output logic [ADDR_W-1:0]      head_addr,
  output logic [DATA_W-1:0]      head_data,
  output logic [2**ADDR_W-1:0]   busy
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

  logic [DEPTH-1:0][ADDR_W-1:0] addr_q;
  logic [DEPTH-1:0][DATA_W-1:0] data_q;
  logic [PW-1:0] wptr, rptr, off;
  logic [PW:0]   cnt;
  logic          push, pop_ok;

  // Ready looks only at stored occupancy; a full queue stays closed even
  // when it is being popped on the same edge. Reset is the only other term.
  assign ready     = ~rst & (cnt != FULL);
  assign push      = valid & ready;
  assign nonempty  = (cnt != '0);
  assign pop_ok    = pop & nonempty;
  assign head_addr = addr_q[rptr];
  assign head_data = data_q[rptr];

  // Entry storage; contents only matter where the pointers say they are valid.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[wptr] <= addr;
      data_q[wptr] <= data;
    end
  end

  // Wrap-around pointers and occupancy; reset drops every queued entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (push)   wptr <= wptr + 1'b1;
      if (pop_ok) rptr <= rptr + 1'b1;
      case ({push, pop_ok})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Flag every register targeted by an occupied slot (distance from head < cnt).
  always_comb begin
    busy = '0;
    off  = '0;
    for (int k = 0; k < DEPTH; k++) begin
      off = PW'(k) - rptr;
      if ({1'b0, off} < cnt) busy[addr_q[k]] = 1'b1;
    end
  end
endmodule

module scalar_writeback_arbiter #(
  parameter int DATA_W = 36,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 alu_valid,
  output logic                 alu_ready,
  input  logic [ADDR_W-1:0]    alu_addr,
  input  logic [DATA_W-1:0]    alu_data,
  input  logic                 mem_valid,
  output logic                 mem_ready,
  input  logic [ADDR_W-1:0]    mem_addr,
  input  logic [DATA_W-1:0]    mem_data,
  output logic                 we,
  output logic [ADDR_W-1:0]    write_addr,
  output logic [DATA_W-1:0]    write_data,
  output logic [2**ADDR_W-1:0] busy
);
  // Lane 0 is the ALU producer, lane 1 the load producer.
  localparam int NUM_LANES = 2;
  localparam int NREG      = 2**ADDR_W;

  logic [NUM_LANES-1:0]             in_valid, ready, nonempty, gnt;
  logic [NUM_LANES-1:0][ADDR_W-1:0] in_addr, head_addr;
  logic [NUM_LANES-1:0][DATA_W-1:0] in_data, head_data;
  logic [NUM_LANES-1:0][NREG-1:0]   lane_busy;
  logic                             alu_next;

  assign in_valid  = {mem_valid, alu_valid};
  assign in_addr   = {mem_addr, alu_addr};
  assign in_data   = {mem_data, alu_data};
  assign alu_ready = ready[0];
  assign mem_ready = ready[1];

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    scalar_writeback_arbiter_lane #(
      .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)
    ) u_lane (
      .clk       (clk),
      .rst       (rst),
      .valid     (in_valid[i]),
      .addr      (in_addr[i]),
      .data      (in_data[i]),
      .pop       (gnt[i]),
      .ready     (ready[i]),
      .nonempty  (nonempty[i]),
      .head_addr (head_addr[i]),
      .head_data (head_data[i]),
      .busy      (lane_busy[i])
    );
  end

  // Sole requester wins outright; on contention the pointer picks.
  assign gnt[0] = nonempty[0] & (~nonempty[1] | alu_next);
  assign gnt[1] = nonempty[1] & (~nonempty[0] | ~alu_next);

  // Registered write port and round-robin pointer; address/data hold when idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we         <= 1'b0;
      write_addr <= '0;
      write_data <= '0;
      alu_next   <= 1'b1;
    end else begin
      we <= |nonempty;
      if (|nonempty) begin
        write_addr <= gnt[1] ? head_addr[1] : head_addr[0];
        write_data <= gnt[1] ? head_data[1] : head_data[0];
        alu_next   <= gnt[1];
      end
    end
  end

  // Pending writes: anything still queued plus the write being presented now.
  always_comb begin
    busy = lane_busy[0] | lane_busy[1];
    if (we) busy[write_addr] = 1'b1;
  end
endmodule

// File: tb/tb_scalar_writeback_arbiter.sv
// Bench for scalar_writeback_arbiter: table of single-push vectors plus
// hand-written contention, full-queue and mid-flight reset sequences.
// A negedge monitor pops expected writes from a scoreboard queue.
module tb_scalar_writeback_arbiter;
  localparam int DATA_W = 36;
  localparam int ADDR_W = 5;
  localparam int DEPTH  = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              alu_valid = 1'b0, mem_valid = 1'b0;
  logic [ADDR_W-1:0] alu_addr = '0, mem_addr = '0;
  logic [DATA_W-1:0] alu_data = '0, mem_data = '0;
  logic              alu_ready, mem_ready, we;
  logic [ADDR_W-1:0] write_addr;
  logic [DATA_W-1:0] write_data;
  logic [31:0]       busy;

  scalar_writeback_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_addr(alu_addr), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_data(mem_data),
    .we(we), .write_addr(write_addr), .write_data(write_data), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct { logic [ADDR_W-1:0] addr; logic [DATA_W-1:0] data; } wr_t;
  typedef struct {
    bit                port;      // 0 = alu, 1 = mem
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [ADDR_W-1:0] exp_addr;
    logic [DATA_W-1:0] exp_data;
  } vec_t;

  wr_t  exp_q[$];
  vec_t vecs[6];
  int   n_vec = 0, n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic expect_wr(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    wr_t w;
    w.addr = a;
    w.data = d;
    exp_q.push_back(w);
  endtask

  // Present inputs for one edge, return at the following negedge with valids low.
  task automatic drive(input logic av, input logic [ADDR_W-1:0] aa, input logic [DATA_W-1:0] ad,
                       input logic mv, input logic [ADDR_W-1:0] ma, input logic [DATA_W-1:0] md);
    alu_valid = av; alu_addr = aa; alu_data = ad;
    mem_valid = mv; mem_addr = ma; mem_data = md;
    @(posedge clk);
    @(negedge clk);
    alu_valid = 1'b0;
    mem_valid = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Called just after a negedge; returns just after the next negedge, out of reset.
  task automatic do_reset();
    #1 rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  // Scoreboard: every write must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && we) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_write: got addr %0d data %h, want no write (t=%0t)",
                 write_addr, write_data, $time);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("wr_addr", 64'(write_addr), 64'(e.addr));
        check("wr_data", 64'(write_data), 64'(e.data));
      end
    end
  end

  initial begin
    vecs[0] = '{1'b0, 5'd3,  36'h123456789, 5'd3,  36'h123456789};
    vecs[1] = '{1'b0, 5'd7,  36'h000000077, 5'd7,  36'h000000077};
    vecs[2] = '{1'b1, 5'd0,  36'hFFFFFFFFF, 5'd0,  36'hFFFFFFFFF};
    vecs[3] = '{1'b1, 5'd31, 36'h000000000, 5'd31, 36'h000000000};
    vecs[4] = '{1'b0, 5'd0,  36'hA5A5A5A5A, 5'd0,  36'hA5A5A5A5A};
    vecs[5] = '{1'b1, 5'd18, 36'h800000001, 5'd18, 36'h800000001};

    // Reset state
    #1 rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("rst_we",    64'(we), 64'd0);
    check("rst_waddr", 64'(write_addr), 64'd0);
    check("rst_wdata", 64'(write_data), 64'd0);
    check("rst_busy",  64'(busy), 64'd0);
    check("rst_alu_ready", 64'(alu_ready), 64'd0);
    check("rst_mem_ready", 64'(mem_ready), 64'd0);
    rst = 1'b0;
    #1;
    check("rel_alu_ready", 64'(alu_ready), 64'd1);
    check("rel_mem_ready", 64'(mem_ready), 64'd1);

    // Single pushes: latency, busy window, address 0 and 31
    for (int i = 0; i < 6; i++) begin
      logic [31:0] oh;
      oh = 32'd1 << vecs[i].addr;
      check("vec_ready", 64'(vecs[i].port ? mem_ready : alu_ready), 64'd1);
      expect_wr(vecs[i].exp_addr, vecs[i].exp_data);
      if (vecs[i].port) drive(1'b0, '0, '0, 1'b1, vecs[i].addr, vecs[i].data);
      else              drive(1'b1, vecs[i].addr, vecs[i].data, 1'b0, '0, '0);
      check("vec_we_early", 64'(we), 64'd0);
      check("vec_busy_queued", 64'(busy), 64'(oh));
      step();
      check("vec_we", 64'(we), 64'd1);
      check("vec_busy_writing", 64'(busy), 64'(oh));
      step();
      check("vec_we_off", 64'(we), 64'd0);
      check("vec_busy_clear", 64'(busy), 64'd0);
    end

    // Contention after reset: 1, 10, 2, 11 back to back
    do_reset();
    expect_wr(5'd1,  36'h100000001);
    expect_wr(5'd10, 36'h20000000A);
    expect_wr(5'd2,  36'h100000002);
    expect_wr(5'd11, 36'h20000000B);
    drive(1'b1, 5'd1, 36'h100000001, 1'b1, 5'd10, 36'h20000000A);
    check("ct_we0", 64'(we), 64'd0);
    drive(1'b1, 5'd2, 36'h100000002, 1'b1, 5'd11, 36'h20000000B);
    check("ct_we1", 64'(we), 64'd1);
    check("ct_busy", 64'(busy), 64'h0000_0C06);
    step(); check("ct_we2", 64'(we), 64'd1);
    step(); check("ct_we3", 64'(we), 64'd1);
    step(); check("ct_we4", 64'(we), 64'd1);
    step(); check("ct_idle", 64'(we), 64'd0);
    check("ct_drained", 64'(exp_q.size()), 64'd0);

    // Full load queue with backpressure while ALU stays non-empty
    do_reset();
    expect_wr(5'd4,  36'h0000000A1);
    expect_wr(5'd20, 36'h0000000B1);
    expect_wr(5'd5,  36'h0000000A2);
    expect_wr(5'd21, 36'h0000000B2);
    expect_wr(5'd6,  36'h0000000A3);
    expect_wr(5'd22, 36'h0000000B3);
    drive(1'b1, 5'd4, 36'h0000000A1, 1'b1, 5'd20, 36'h0000000B1);
    check("full_ready_1", 64'(mem_ready), 64'd1);
    drive(1'b1, 5'd5, 36'h0000000A2, 1'b1, 5'd21, 36'h0000000B2);
    check("full_ready_2", 64'(mem_ready), 64'd0);
    drive(1'b1, 5'd6, 36'h0000000A3, 1'b1, 5'd22, 36'h0000000B3);
    check("full_ready_3", 64'(mem_ready), 64'd1);
    check("full_alu_ready", 64'(alu_ready), 64'd0);
    drive(1'b0, '0, '0, 1'b1, 5'd22, 36'h0000000B3);
    check("full_ready_4", 64'(mem_ready), 64'd0);
    repeat (4) step();
    check("full_idle", 64'(we), 64'd0);
    check("full_drained", 64'(exp_q.size()), 64'd0);

    // Reset mid-flight: queued entries discarded
    do_reset();
    expect_wr(5'd1, 36'h100000001);
    drive(1'b1, 5'd1, 36'h100000001, 1'b1, 5'd10, 36'h20000000A);
    drive(1'b1, 5'd2, 36'h100000002, 1'b1, 5'd11, 36'h20000000B);
    check("mf_we_before", 64'(we), 64'd1);
    #2 rst = 1'b1;
    exp_q.delete();
    #1;
    check("mf_we_rst",   64'(we), 64'd0);
    check("mf_busy_rst", 64'(busy), 64'd0);
    check("mf_waddr_rst", 64'(write_addr), 64'd0);
    check("mf_alu_ready_rst", 64'(alu_ready), 64'd0);
    check("mf_mem_ready_rst", 64'(mem_ready), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("mf_alu_ready_rel", 64'(alu_ready), 64'd1);
    check("mf_mem_ready_rel", 64'(mem_ready), 64'd1);
    for (int c = 0; c < 5; c++) begin
      step();
      check("mf_no_write", 64'(we), 64'd0);
      check("mf_busy_clear", 64'(busy), 64'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/scalar_writeback_arbiter.md
SCALAR_WRITEBACK_ARBITER -- requirements
Module: scalar_writeback_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, default 36, meaning register data width.
REQ-002 SHALL have parameter ADDR_W, default 5, meaning register address width (32 registers).
REQ-003 SHALL have parameter DEPTH, default 2, meaning entries per input queue (power of two, >=2).
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have ports alu_valid input 1, alu_ready output 1, alu_addr input ADDR_W, alu_data input DATA_W: ALU result producer.
REQ-007 SHALL have ports mem_valid input 1, mem_ready output 1, mem_addr input ADDR_W, mem_data input DATA_W: load result producer.
REQ-008 SHALL have ports we output 1, write_addr output ADDR_W, write_data output DATA_W: register file write port.
REQ-009 SHALL have port busy  output  2**ADDR_W  per-register pending-write flags for decode stall logic.

Function
REQ-010 SHALL hold one FIFO of DEPTH entries {addr, data} per producer; a push occurs on a rising edge where valid and ready are both high.
REQ-011 SHALL drive x_ready = 1 exactly when that FIFO holds fewer than DEPTH entries, using registered occupancy only (no combinational path from any input to any ready).
REQ-012 SHALL deassert x_ready while full even if the same edge pops that FIFO (no full-queue pass-through).
REQ-013 SHALL accept push and pop on the same edge for a non-full FIFO; occupancy is then unchanged.
REQ-014 SHALL ignore x_addr/x_data when x_valid is low or x_ready is low.
REQ-015 SHALL drive we, write_addr and write_data from registers only.
REQ-016 SHALL, on each edge where at least one FIFO is non-empty, pop exactly one head (the grant) and load it into write_addr/write_data with we = 1.
REQ-017 SHALL, on each edge where both FIFOs are empty, load we = 0 and hold write_addr/write_data unchanged.
REQ-018 SHALL grant the only non-empty FIFO when only one is non-empty.
REQ-019 SHALL, when both are non-empty, grant round-robin: the port not granted on the most recent grant wins; pointer updates only on a grant.
REQ-020 SHALL preserve per-port order; write order between the two ports is arbitration order only.
REQ-021 SHALL give latency: entry pushed at edge E, with no competition and empty queue, appears as we = 1 during the cycle after edge E+1.
REQ-022 SHALL sustain one write per cycle while either FIFO is non-empty.
REQ-023 SHALL set busy[r] = 1 when any valid entry in either FIFO, or the output register with we = 1, targets register r; busy is combinational from registered state.
REQ-024 SHALL treat address 0 like any other address (no suppression).
REQ-025 SHALL use wrap-around read/write pointers of log2(DEPTH) bits plus registered occupancy count.

Reset
REQ-026 SHALL, while rst is high, asynchronously force: both FIFOs empty, we = 0, write_addr = 0, write_data = 0, busy = 0, round-robin pointer to "ALU wins next".
REQ-027 SHALL force alu_ready = mem_ready = 0 while rst is high and 1 on the first cycle after release.
REQ-028 SHALL discard all queued entries when rst asserts mid-operation; none are written after release.

Verification
REQ-029 Single push: alu push {addr 3, data 0x123456789} at edge E, idle otherwise -> we = 1, write_addr = 3, write_data = 0x123456789 in the cycle after E+1, we = 0 in the next cycle.
REQ-030 Contention: both FIFOs hold 2 entries after reset (ALU addr 1, 2; mem addr 10, 11) -> writes in order 1, 10, 2, 11 on consecutive cycles, we low afterwards.
REQ-031 Full: mem held valid with 3 distinct entries while ALU queue is kept non-empty -> mem_ready drops after 2 pushes, third entry accepted only once occupancy < 2, and it is written after the first two.
REQ-032 Busy: ALU push addr 7 -> busy[7] = 1 from the cycle after the push through the cycle with we = 1, write_addr = 7, and 0 on the following cycle.
REQ-033 Reset mid-flight: rst pulses with 2 entries queued per port and we = 1 -> we = 0, busy = 0 immediately; no writes after release; ready = 1 on both ports.
